// File: rtl/branch_update_unit_pkg.sv
// Shared predictor types: update FSM states, 2-bit counter constants and queue entry.
package branch_update_unit_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CTR_W  = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      WRITE   = 2'd2,
      RELEASE = 2'd3
   } bu_state_e;

   localparam logic [CTR_W-1:0] STRONG_NT = 2'd0;
   localparam logic [CTR_W-1:0] WEAK_NT   = 2'd1;
   localparam logic [CTR_W-1:0] WEAK_T    = 2'd2;
   localparam logic [CTR_W-1:0] STRONG_T  = 2'd3;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              taken;
   } bu_entry_t;

   // Saturating step of a 2-bit bimodal counter towards the actual outcome.
   function automatic logic [CTR_W-1:0] sat_update(input logic [CTR_W-1:0] cnt, input logic taken);
      if (taken)
         return (cnt == STRONG_T) ? STRONG_T : cnt + CTR_W'(1);
      else
         return (cnt == STRONG_NT) ? STRONG_NT : cnt - CTR_W'(1);
   endfunction

endpackage

// File: rtl/branch_update_fifo.sv
// Resolved-branch queue; pointers carry an extra wrap bit to tell full from empty.
module branch_update_fifo
   import branch_update_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  bu_entry_t wdata,
   input  logic      pop,
   input  logic      flush,
   output bu_entry_t rdata,
   output logic      full,
   output logic      empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   bu_entry_t   mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/branch_update_unit.sv
// Drains committed branch outcomes into the predictor table: read counter, update, write back.
module branch_update_unit
   import branch_update_unit_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              resolveValid,
   output logic              resolveReady,
   input  logic [31:0]       resolveAddr,
   input  logic              resolveTaken,
   input  logic              flush,
   output logic [31:0]       branchROBReadAddr,
   input  logic [31:0]       branchROBPredict,
   output logic              branchWriteEnable,
   output logic [1:0]        branchWriteData,
   output logic [31:0]       branchWriteAddr,
   output logic              busy,
   output logic [CNT_W-1:0]  updateCount,
   output logic [CNT_W-1:0]  mispredictCount
);

   bu_state_e         state;
   bu_entry_t         head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ADDR_W-1:0] cur_addr;
   logic              cur_taken;
   logic [CTR_W-1:0]  cur_cnt;
   logic [CTR_W-1:0]  new_cnt;
   logic              unused_predict_hi;

   assign unused_predict_hi = ^branchROBPredict[31:2];

   branch_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (resolveValid),
      .wdata ('{addr: resolveAddr, taken: resolveTaken}),
      .pop   (state == IDLE),
      .flush (flush),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign resolveReady = !fifo_full;
   assign busy         = (state != IDLE) || !fifo_empty;
   assign new_cnt      = sat_update(cur_cnt, cur_taken);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         cur_addr          <= '0;
         cur_taken         <= 1'b0;
         cur_cnt           <= STRONG_NT;
         branchROBReadAddr <= '0;
         branchWriteEnable <= 1'b0;
         branchWriteData   <= '0;
         branchWriteAddr   <= '0;
         updateCount       <= '0;
         mispredictCount   <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A flushed head never starts, matching the queue discarding it.
               if (!fifo_empty && !flush) begin
                  cur_addr          <= head.addr;
                  cur_taken         <= head.taken;
                  branchROBReadAddr <= head.addr;
                  state             <= READ;
               end
            end
            READ: begin
               cur_cnt <= branchROBPredict[1:0];
               state   <= WRITE;
            end
            WRITE: begin
               branchWriteEnable <= 1'b1;
               branchWriteData   <= new_cnt;
               branchWriteAddr   <= cur_addr;
               if (updateCount != '1)
                  updateCount <= updateCount + CNT_W'(1);
               if ((cur_cnt[1] != cur_taken) && (mispredictCount != '1))
                  mispredictCount <= mispredictCount + CNT_W'(1);
               state <= RELEASE;
            end
            RELEASE: begin
               branchWriteEnable <= 1'b0;
               state             <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_update_unit.sv
// Scoreboard bench: directed pushes queue expected writes; a negedge monitor checks each pulse.
module tb_branch_update_unit;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        resolveValid;
   logic        resolveReady;
   logic [31:0] resolveAddr;
   logic        resolveTaken;
   logic        flush;
   logic [31:0] branchROBReadAddr;
   logic [31:0] branchROBPredict;
   logic        branchWriteEnable;
   logic [1:0]  branchWriteData;
   logic [31:0] branchWriteAddr;
   logic        busy;
   logic [15:0] updateCount;
   logic [15:0] mispredictCount;

   logic        sat_ready, sat_we, sat_busy;
   logic [31:0] sat_raddr, sat_waddr;
   logic [1:0]  sat_wdata;
   logic [1:0]  sat_upd, sat_mis;

   logic [1:0]  pred;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        exp_q[$];

   // Upper response bits are junk so only [1:0] may matter.
   assign branchROBPredict = {30'h2EADBEEF, pred};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   branch_update_unit #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .resolveValid(resolveValid), .resolveReady(resolveReady),
      .resolveAddr(resolveAddr), .resolveTaken(resolveTaken), .flush(flush),
      .branchROBReadAddr(branchROBReadAddr), .branchROBPredict(branchROBPredict),
      .branchWriteEnable(branchWriteEnable), .branchWriteData(branchWriteData),
      .branchWriteAddr(branchWriteAddr), .busy(busy),
      .updateCount(updateCount), .mispredictCount(mispredictCount)
   );

   // Narrow-counter twin sees identical stimulus to exercise counter saturation.
   branch_update_unit #(.FIFO_DEPTH(4), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .resolveValid(resolveValid), .resolveReady(sat_ready),
      .resolveAddr(resolveAddr), .resolveTaken(resolveTaken), .flush(flush),
      .branchROBReadAddr(sat_raddr), .branchROBPredict(branchROBPredict),
      .branchWriteEnable(sat_we), .branchWriteData(sat_wdata),
      .branchWriteAddr(sat_waddr), .busy(sat_busy),
      .updateCount(sat_upd), .mispredictCount(sat_mis)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && branchWriteEnable === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got write addr %h data %0d at cycle %0d, required none",
                     branchWriteAddr, branchWriteData, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_addr", branchWriteAddr, e.addr);
            chk("wr_data", 32'(branchWriteData), 32'(e.data));
            chk("wr_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic push1(input logic [31:0] a, input logic t, input logic [1:0] d, output int n);
      @(negedge clk);
      resolveValid = 1'b1;
      resolveAddr  = a;
      resolveTaken = t;
      n = cyc + 1;
      exp_q.push_back('{addr: a, data: d, cyc: n + 3});
      @(negedge clk);
      resolveValid = 1'b0;
   endtask

   task automatic drain(input string name);
      int g = 0;
      while ((exp_q.size() != 0 || busy) && g < 100) begin
         @(negedge clk);
         g++;
      end
      n_checks++;
      if (g >= 100) begin
         n_fail++;
         $display("FAIL %s_timeout: got %0d pending writes busy=%b, required drained", name, exp_q.size(), busy);
         exp_q.delete();
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(resolveReady), 32'd1);
      chk({tag, "_we"}, 32'(branchWriteEnable), 32'd0);
      chk({tag, "_wdata"}, 32'(branchWriteData), 32'd0);
      chk({tag, "_waddr"}, branchWriteAddr, 32'd0);
      chk({tag, "_raddr"}, branchROBReadAddr, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_upd"}, 32'(updateCount), 32'd0);
      chk({tag, "_mis"}, 32'(mispredictCount), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, n0, g;
      rst_n = 1'b0; resolveValid = 1'b0; resolveAddr = '0; resolveTaken = 1'b0;
      flush = 1'b0; pred = 2'd0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Weak not-taken, taken outcome: 1 -> 2, mispredict.
      pred = 2'd1;
      push1(32'h40, 1'b1, 2'd2, n);
      drain("t1");
      chk("t1_upd", 32'(updateCount), 32'd1);
      chk("t1_mis", 32'(mispredictCount), 32'd1);
      chk("t1_raddr", branchROBReadAddr, 32'h40);
      chk("t1_hold_addr", branchWriteAddr, 32'h40);
      chk("t1_we_low", 32'(branchWriteEnable), 32'd0);
      chk("t1_sat_upd", 32'(sat_upd), 32'd1);

      // Saturation at both ends of the 2-bit counter.
      pred = 2'd3;
      push1(32'h80, 1'b1, 2'd3, n);
      drain("t2a");
      pred = 2'd0;
      push1(32'hC0, 1'b0, 2'd0, n);
      drain("t2b");
      chk("t2_upd", 32'(updateCount), 32'd3);
      chk("t2_mis", 32'(mispredictCount), 32'd1);

      // Six back-to-back pushes: one starts at once, four fill the queue, the sixth is dropped.
      pred = 2'd2;
      @(negedge clk);
      n0 = cyc + 1;
      for (int k = 0; k < 6; k++) begin
         resolveValid = 1'b1;
         resolveAddr  = 32'h100 + 32'(4 * k);
         resolveTaken = (k % 2) == 1;
         if (k == 4) chk("t3_ready_hi", 32'(resolveReady), 32'd1);
         if (k == 5) chk("t3_ready_full", 32'(resolveReady), 32'd0);
         if (k < 5)
            exp_q.push_back('{addr: 32'h100 + 32'(4 * k), data: ((k % 2) == 1) ? 2'd3 : 2'd1, cyc: n0 + 3 + 4 * k});
         @(negedge clk);
      end
      resolveValid = 1'b0;
      drain("t3");
      chk("t3_upd", 32'(updateCount), 32'd8);
      chk("t3_mis", 32'(mispredictCount), 32'd4);
      chk("t3_sat_upd", 32'(sat_upd), 32'd3);
      chk("t3_sat_mis", 32'(sat_mis), 32'd3);

      // Flush while the first entry is in READ: only it completes.
      pred = 2'd1;
      @(negedge clk);
      n0 = cyc + 1;
      exp_q.push_back('{addr: 32'h200, data: 2'd2, cyc: n0 + 3});
      for (int k = 0; k < 3; k++) begin
         resolveValid = 1'b1;
         resolveAddr  = 32'h200 + 32'(4 * k);
         resolveTaken = 1'b1;
         flush        = (k == 2);
         @(negedge clk);
      end
      resolveValid = 1'b0;
      flush = 1'b0;
      drain("t4");
      repeat (12) @(negedge clk);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_upd", 32'(updateCount), 32'd9);
      chk("t4_ready", 32'(resolveReady), 32'd1);

      // Reset while the write strobe is high.
      pred = 2'd0;
      push1(32'h300, 1'b0, 2'd0, n);
      g = 0;
      while (cyc != n + 3 && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("t5_reach_pulse", 32'(cyc), 32'(n + 3));
      #1 rst_n = 1'b0;
      #1 chk_reset_vals("t5");
      chk("t5_sat_upd", 32'(sat_upd), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Recovery after reset.
      pred = 2'd2;
      push1(32'h400, 1'b1, 2'd3, n);
      drain("t6");
      chk("t6_upd", 32'(updateCount), 32'd1);
      chk("t6_mis", 32'(mispredictCount), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
